// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vga_timing_gen_pkg
//  Description : Shared 640x480@60 timing defaults, derived totals, the
//                sync/blank triple type and a small range-decode helper.
//                Reused by the timing generator, the frame buffer and the
//                game logic so all of them agree on the raster geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    // Default 640x480@60 geometry (pixel clock 25.175 MHz)
    localparam int c_def_h_active = 640;
    localparam int c_def_h_front  = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_back   = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_front  = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_back   = 33;

    localparam int c_def_h_total  = c_def_h_active + c_def_h_front + c_def_h_sync + c_def_h_back;
    localparam int c_def_v_total  = c_def_v_active + c_def_v_front + c_def_v_sync + c_def_v_back;

    // Raster counter width; every supported geometry stays below 1023.
    localparam int c_cnt_w = 10;

    // Undelayed decode of the raster position, active-high in every field.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // True when value lies in the closed interval [lo, hi].
    function automatic logic in_window(input logic [c_cnt_w-1:0] value,
                                       input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) <= hi);
    endfunction

endpackage : vga_timing_gen_pkg
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sync_delay_line
//  Description : Parameterised WIDTH x DEPTH shift register with an
//                asynchronous active-low reset that loads every stage with
//                RESET_VALUE. DEPTH must be at least 1; callers that need a
//                zero-length delay bypass this block entirely.
//  Ports       : clk   - clock
//                reset - asynchronous active-low reset
//                din   - data into stage 0
//                dout  - data out of the last stage (DEPTH cycles late)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VALUE;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule : sync_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Pixel timebase and VGA output stage. Produces the raster
//                counters for the frame buffer, receives its 1-bit colour
//                PIPE_DELAY cycles later, and drives hsync/vsync/RGB with
//                sync and blanking delayed to line up with that colour.
//                Also provides line/frame strobes and a frame counter.
//  Ports       : clk          - pixel clock, one pixel per cycle
//                reset        - asynchronous active-low reset
//                colour_in    - frame buffer pixel (1 = white)
//                counter_H/V  - raster position, undelayed
//                line_start   - 1-clk pulse while counter_H has just wrapped
//                frame_start  - 1-clk pulse while (H,V) has just wrapped
//                frame_count  - frames since reset, wraps 255 -> 0
//                hsync/vsync  - pipeline-aligned syncs, asserted = SYNC_POL
//                display_on   - pipeline-aligned active-area flag
//                vga_r/g/b    - {2{colour_in}} in the active area, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE   = c_def_h_active,
    parameter int   H_FRONT    = c_def_h_front,
    parameter int   H_SYNC     = c_def_h_sync,
    parameter int   H_BACK     = c_def_h_back,
    parameter int   V_ACTIVE   = c_def_v_active,
    parameter int   V_FRONT    = c_def_v_front,
    parameter int   V_SYNC     = c_def_v_sync,
    parameter int   V_BACK     = c_def_v_back,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               colour_in,
    output logic [c_cnt_w-1:0] counter_H,
    output logic [c_cnt_w-1:0] counter_V,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [1:0]         vga_r,
    output logic [1:0]         vga_g,
    output logic [1:0]         vga_b
);

    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [c_cnt_w-1:0] c_h_last = c_cnt_w'(c_h_total - 1);
    localparam logic [c_cnt_w-1:0] c_v_last = c_cnt_w'(c_v_total - 1);
    localparam logic [c_cnt_w-1:0] c_h_act  = c_cnt_w'(H_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_v_act  = c_cnt_w'(V_ACTIVE);

    localparam int c_hs_first = H_ACTIVE + H_FRONT;
    localparam int c_hs_last  = H_ACTIVE + H_FRONT + H_SYNC - 1;
    localparam int c_vs_first = V_ACTIVE + V_FRONT;
    localparam int c_vs_last  = V_ACTIVE + V_FRONT + V_SYNC - 1;

    // ------------------------------------------------------------------
    // Raster counters and strobes
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_h;
    logic [c_cnt_w-1:0] r_v;
    logic               r_line_start;
    logic               r_frame_start;
    logic [7:0]         r_frame_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            // Strobes are registered alongside the wrap so they are high
            // exactly while the counters read the wrapped value.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_h == c_h_last) begin
                r_h          <= '0;
                r_line_start <= 1'b1;
                if (r_v == c_v_last) begin
                    r_v           <= '0;
                    r_frame_start <= 1'b1;
                    r_frame_count <= r_frame_count + 8'd1;
                end else begin
                    r_v <= r_v + c_cnt_w'(1);
                end
            end else begin
                r_h <= r_h + c_cnt_w'(1);
            end
        end
    end

    assign counter_H   = r_h;
    assign counter_V   = r_v;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

    // ------------------------------------------------------------------
    // Decode on the undelayed counters
    // ------------------------------------------------------------------
    sync_t w_raw;
    sync_t w_dly;

    assign w_raw.hs = in_window(r_h, c_hs_first, c_hs_last);
    assign w_raw.vs = in_window(r_v, c_vs_first, c_vs_last);
    assign w_raw.de = (r_h < c_h_act) && (r_v < c_v_act);

    // ------------------------------------------------------------------
    // Delay the decode by the frame buffer latency so it meets colour_in
    // at the output register. Stages reset to "sync inactive, blanked".
    // ------------------------------------------------------------------
    generate
        if (PIPE_DELAY > 0) begin : g_delay
            sync_delay_line #(
                .WIDTH       (3),
                .DEPTH       (PIPE_DELAY),
                .RESET_VALUE (3'b000)
            ) u_sync_delay_line (
                .clk   (clk),
                .reset (reset),
                .din   (w_raw),
                .dout  (w_dly)
            );
        end else begin : g_no_delay
            assign w_dly = w_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: samples the delayed triple and colour_in together
    // ------------------------------------------------------------------
    logic w_pixel_on;
    assign w_pixel_on = w_dly.de & colour_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            display_on <= 1'b0;
            vga_r      <= 2'b00;
            vga_g      <= 2'b00;
            vga_b      <= 2'b00;
        end else begin
            hsync      <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
            vsync      <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
            display_on <= w_dly.de;
            vga_r      <= {2{w_pixel_on}};
            vga_g      <= {2{w_pixel_on}};
            vga_b      <= {2{w_pixel_on}};
        end
    end

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench. Three instances share clk/reset/
//                colour_in: a compact raster with PIPE_DELAY=2 (small
//                enough to wrap frame_count), the same raster with
//                PIPE_DELAY=0 and active-high sync, and the default
//                640x480 raster. Every cycle each instance is compared
//                against a reference computed arithmetically from the
//                number of clock edges since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic colour_in;

    always #5 clk = ~clk;

    // ---------------- instance A: small raster, delay 2, active-low sync
    logic [9:0] a_h, a_v; logic a_ls, a_fs; logic [7:0] a_fc;
    logic a_hs, a_vs, a_de; logic [1:0] a_r, a_g, a_b;
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .PIPE_DELAY(2)
    ) dut_a (
        .clk(clk), .reset(reset), .colour_in(colour_in),
        .counter_H(a_h), .counter_V(a_v), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    // ---------------- instance B: small raster, no delay, active-high sync
    logic [9:0] b_h, b_v; logic b_ls, b_fs; logic [7:0] b_fc;
    logic b_hs, b_vs, b_de; logic [1:0] b_r, b_g, b_b;
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b1), .PIPE_DELAY(0)
    ) dut_b (
        .clk(clk), .reset(reset), .colour_in(colour_in),
        .counter_H(b_h), .counter_V(b_v), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
    );

    // ---------------- instance C: default 640x480 raster, delay 2
    logic [9:0] c_h, c_v; logic c_ls, c_fs; logic [7:0] c_fc;
    logic c_hs, c_vs, c_de; logic [1:0] c_r, c_g, c_b;
    vga_timing_gen dut_c (
        .clk(clk), .reset(reset), .colour_in(colour_in),
        .counter_H(c_h), .counter_V(c_v), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc), .hsync(c_hs), .vsync(c_vs), .display_on(c_de),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
    );

    int   n_checks = 0;
    int   n_fails  = 0;
    int   k;            // clock edges since reset release
    logic colour_prev;  // colour_in during cycle k-1

    // Expected {H,V,line_start,frame_start,frame_count,hsync,vsync,de,r,g,b}
    // during the cycle after k edges. Position is plain division of k by
    // the line/frame length; aligned outputs describe position k-p-1 and
    // show the colour that was on the input one cycle earlier.
    function automatic logic [38:0] model(input int kk,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb,
                                          input int p, input logic pol, input logic cprev);
        int ht, vt, h, v, fc, j, hj, vj;
        logic ls, fs, hsa, vsa, de, px;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = kk % ht;
        v  = (kk / ht) % vt;
        fc = (kk / (ht * vt)) % 256;
        ls = (kk > 0) && (h == 0);
        fs = (kk > 0) && (h == 0) && (v == 0);
        hsa = 1'b0; vsa = 1'b0; de = 1'b0;
        if (kk >= p + 1) begin
            j   = kk - p - 1;
            hj  = j % ht;
            vj  = (j / ht) % vt;
            hsa = (hj >= ha + hf) && (hj < ha + hf + hs);
            vsa = (vj >= va + vf) && (vj < va + vf + vs);
            de  = (hj < ha) && (vj < va);
        end
        px = de && cprev;
        return {10'(h), 10'(v), ls, fs, 8'(fc),
                (hsa ? pol : ~pol), (vsa ? pol : ~pol), de,
                {6{px}}};
    endfunction

    task automatic check_all();
        logic [38:0] obs, exp_v;
        obs   = {a_h, a_v, a_ls, a_fs, a_fc, a_hs, a_vs, a_de, a_r, a_g, a_b};
        exp_v = model(k, 8, 2, 3, 3, 5, 1, 2, 2, 2, 1'b0, colour_prev);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL dut_a k=%0d observed=%h expected=%h", k, obs, exp_v);
        end
        obs   = {b_h, b_v, b_ls, b_fs, b_fc, b_hs, b_vs, b_de, b_r, b_g, b_b};
        exp_v = model(k, 8, 2, 3, 3, 5, 1, 2, 2, 0, 1'b1, colour_prev);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL dut_b k=%0d observed=%h expected=%h", k, obs, exp_v);
        end
        obs   = {c_h, c_v, c_ls, c_fs, c_fc, c_hs, c_vs, c_de, c_r, c_g, c_b};
        exp_v = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, colour_prev);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL dut_c k=%0d observed=%h expected=%h", k, obs, exp_v);
        end
    endtask

    // Colour pattern: tied high, then toggling every clock, then random.
    function automatic logic next_colour(input int kk);
        if (kk < 1000)      return 1'b1;
        else if (kk < 2000) return kk[0];
        else                return 1'($urandom_range(0, 1));
    endfunction

    // Advance one clock and compare every instance.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        colour_prev = colour_in;
        colour_in   = next_colour(k);
        check_all();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset       = 1'b1;
        k           = 0;
        colour_prev = 1'b0;
        check_all();
    endtask

    initial begin
        reset       = 1'b0;
        colour_in   = 1'b1;
        colour_prev = 1'b0;
        k           = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();                       // held in reset
        release_reset();

        // Two-plus lines of the large raster, many lines of the small one.
        repeat (1700) tick();

        // Asynchronous reset mid-line: outputs must clear within the cycle.
        #3;
        reset = 1'b0;
        k     = 0;
        #1;
        check_all();
        release_reset();

        // Over 256 frames of the small raster so frame_count wraps.
        repeat (41500) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
